j_pulse_ctl: RTL and testbench
==============================

J_PULSE_CTL -- requirements
Module: j_pulse_ctl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port wr_en, input, 1 bit: register write strobe, one write per cycle.
REQ-004 SHALL have port wr_addr, input, 2 bits: write register select.
REQ-005 SHALL have port wr_data, input, 16 bits: write data.
REQ-006 SHALL have port rd_addr, input, 2 bits: read register select.
REQ-007 SHALL have port rd_data, output, 16 bits: registered read data, 1-cycle latency.
REQ-008 SHALL have port pa, output, 8 bits: prescale value driven to the pulse generator.
REQ-009 SHALL have port pb, output, 7 bits: divide value driven to the pulse generator.
REQ-010 SHALL have port pstop, output, 1 bit: stop/hold to the pulse generator, 1 = halted.
REQ-011 SHALL have port pulse_in, input, 1 bit: single-cycle pulse returned by the pulse generator.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-013 SHALL decode register addresses as follows: 0 = CTRL (bit0 enable, bit1 oneshot, bit2 irq_en); 1 = DIV shadow (bits 7:0 = a, bits 14:8 = b); 2 = TARGET (16-bit pulse count per event); 3 = STATUS.
REQ-014 SHALL, on a write to STATUS, clear the pending flag when wr_data bit0 = 1 (write-1-to-clear) and ignore all other bits.
REQ-015 SHALL return STATUS on read as: bit0 pending, bits 2:1 state (0 IDLE, 1 LOAD, 2 RUN), bit3 reload_pend, bits 15:4 = pulse count bits 11:0.
REQ-016 SHALL return CTRL, DIV and TARGET on read as last written, with unused bits reading 0.
REQ-017 SHALL implement state IDLE: pstop = 1, pulse count held at 0; leaves for LOAD in the cycle after enable = 1 is observed.
REQ-018 SHALL implement state LOAD: exactly 1 cycle; pa/pb <= DIV shadow; pstop = 1; reload_pend cleared; next state RUN.
REQ-019 SHALL implement state RUN: pstop = 0; each pulse_in = 1 increments the 16-bit pulse count.
REQ-020 SHALL, in RUN, on pulse_in when count = TARGET-1, set count to 0 and set pending; TARGET = 0 SHALL be treated as 1.
REQ-021 SHALL, on that terminal pulse with oneshot = 1, clear CTRL.enable and go to IDLE.
REQ-022 SHALL, on a DIV write while in RUN, set reload_pend; pa/pb SHALL NOT change mid-period.
REQ-023 SHALL, on the next pulse_in with reload_pend = 1, count that pulse normally and then go to LOAD.
REQ-024 SHALL ignore pulse_in while in IDLE or LOAD.
REQ-025 SHALL, on a DIV write while in IDLE, only update the shadow; it is applied at the next LOAD.
REQ-026 SHALL, when enable is cleared by write in LOAD or RUN, go to IDLE next cycle, clear count and reload_pend, and keep pending.
REQ-027 SHALL give set priority when a pending set and a STATUS clear occur in the same cycle: pending = 1.
REQ-028 SHALL, on a simultaneous oneshot terminal pulse and a CTRL write, let the CTRL write value win for enable.
REQ-029 SHALL drive irq = pending AND irq_en, combinationally from registered flops only.
REQ-030 SHALL make TARGET writes take effect for the next comparison without resetting count; if count >= new TARGET, the event SHALL fire when count wraps to TARGET-1 (16-bit wrap).

Reset
REQ-031 SHALL, with reset = 1, set state IDLE, pstop = 1, pa = 0, pb = 0, CTRL/DIV/TARGET = 0, count = 0, pending = 0, reload_pend = 0, irq = 0 and rd_data = 0.
REQ-032 SHALL give reset priority over all writes and pulse_in in the same cycle.
REQ-033 SHALL, on reset asserted mid-RUN, return to IDLE on the next edge with pstop = 1.

Verification
REQ-034 SHALL pass this scenario: DIV = 0x0305, TARGET = 3, CTRL = 0x5, three pulse_in -> pa = 0x05, pb = 0x03, one LOAD cycle with pstop = 1, pending = 1 and irq = 1 after the 3rd pulse, count = 0.
REQ-035 SHALL pass this scenario: CTRL = 0x7, TARGET = 2, two pulses -> irq = 1, enable = 0, state IDLE, pstop = 1; further pulses leave count = 0.
REQ-036 SHALL pass this scenario: in RUN, write DIV = 0x0A10 -> pa/pb unchanged until the next pulse_in, then 1 LOAD cycle, then pa = 0x10, pb = 0x0A; reload_pend reads 1 in between.
REQ-037 SHALL pass this scenario: terminal pulse_in in the same cycle as a STATUS write of 0x0001 -> pending = 1 afterwards.
REQ-038 SHALL pass this scenario: reset asserted in RUN with count = 5 -> all outputs at reset values next cycle; rd_data of STATUS = 0.
REQ-039 SHALL pass this scenario: TARGET = 0, CTRL = 0x5 -> pending sets on every pulse_in.

Source files
------------

// File: rtl/j_pulse_ctl.sv
// rtl/j_pulse_ctl.sv - register-programmed controller for an external prescaled pulse generator
module j_pulse_ctl (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [7:0]  pa,
    output logic [6:0]  pb,
    output logic        pstop,
    input  logic        pulse_in,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_TARGET = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    state_t      state;
    state_t      state_next;

    logic        ctrl_enable;
    logic        ctrl_oneshot;
    logic        ctrl_irq_en;
    logic [7:0]  div_a;
    logic [6:0]  div_b;
    logic [15:0] target;
    logic [15:0] count;
    logic        pending;
    logic        reload_pend;

    logic        wr_ctrl;
    logic        wr_div;
    logic        wr_target;
    logic        wr_status;
    logic [15:0] target_last;
    logic        run_pulse;
    logic        terminal;
    logic        oneshot_stop;
    logic        user_stop;
    logic [1:0]  state_code;
    logic [15:0] status_word;

    // Write decode and run-time event qualifiers shared by the FSM and datapath
    always_comb begin
        wr_ctrl      = wr_en && (wr_addr == ADDR_CTRL);
        wr_div       = wr_en && (wr_addr == ADDR_DIV);
        wr_target    = wr_en && (wr_addr == ADDR_TARGET);
        wr_status    = wr_en && (wr_addr == ADDR_STATUS);
        // A target of zero behaves as one: every pulse is terminal
        target_last  = (target == 16'd0) ? 16'd0 : (target - 16'd1);
        run_pulse    = (state == ST_RUN) && pulse_in;
        terminal     = run_pulse && (count == target_last);
        oneshot_stop = terminal && ctrl_oneshot;
        // Software clearing enable while active aborts the sequence
        user_stop    = wr_ctrl && !wr_data[0] && (state != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: abort, then oneshot completion, then deferred reload
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ctrl_enable) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (user_stop) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (user_stop || oneshot_stop) begin
                    state_next = ST_IDLE;
                end else if (run_pulse && reload_pend) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Programmable registers; a CTRL write overrides the oneshot self-disable
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_enable  <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            div_a        <= 8'd0;
            div_b        <= 7'd0;
            target       <= 16'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable  <= wr_data[0];
                ctrl_oneshot <= wr_data[1];
                ctrl_irq_en  <= wr_data[2];
            end else if (oneshot_stop) begin
                ctrl_enable <= 1'b0;
            end
            if (wr_div) begin
                div_a <= wr_data[7:0];
                div_b <= wr_data[14:8];
            end
            if (wr_target) begin
                target <= wr_data;
            end
        end
    end

    // Pulse counter: held at zero whenever idle, wraps at 16 bits otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 16'd0;
        end else if (state_next == ST_IDLE) begin
            count <= 16'd0;
        end else if (run_pulse) begin
            count <= terminal ? 16'd0 : (count + 16'd1);
        end
    end

    // Pending event flag: a terminal pulse beats a same-cycle W1C clear
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (terminal) begin
            pending <= 1'b1;
        end else if (wr_status && wr_data[0]) begin
            pending <= 1'b0;
        end
    end

    // Deferred divider reload: armed by a DIV write while running, consumed in LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_pend <= 1'b0;
        end else if ((state == ST_LOAD) || (state_next == ST_IDLE)) begin
            reload_pend <= 1'b0;
        end else if (wr_div && (state == ST_RUN)) begin
            reload_pend <= 1'b1;
        end
    end

    // Generator divider outputs only change in LOAD so a period is never cut short
    always_ff @(posedge clk) begin
        if (reset) begin
            pa <= 8'd0;
            pb <= 7'd0;
        end else if (state == ST_LOAD) begin
            pa <= div_a;
            pb <= div_b;
        end
    end

    // Status word assembly
    always_comb begin
        state_code  = state;
        status_word = {count[11:0], reload_pend, state_code, pending};
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 16'd0;
        end else begin
            case (rd_addr)
                ADDR_CTRL:   rd_data <= {13'd0, ctrl_irq_en, ctrl_oneshot, ctrl_enable};
                ADDR_DIV:    rd_data <= {1'b0, div_b, div_a};
                ADDR_TARGET: rd_data <= target;
                default:     rd_data <= status_word;
            endcase
        end
    end

    // Generator hold and interrupt come straight from flops
    always_comb begin
        pstop = (state != ST_RUN);
        irq   = pending && ctrl_irq_en;
    end

endmodule

// File: tb/tb_j_pulse_ctl.sv
// tb/tb_j_pulse_ctl.sv - scoreboard bench for j_pulse_ctl against a behavioural model
module tb_j_pulse_ctl;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_RUN  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  pa;
    logic [6:0]  pb;
    logic        pstop;
    logic        pulse_in;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] rd;
        logic [7:0]  pa;
        logic [6:0]  pb;
        logic        pstop;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic        m_en, m_os, m_ie;
    logic [7:0]  m_a, m_pa;
    logic [6:0]  m_b, m_pb;
    logic [15:0] m_tgt, m_cnt;
    logic        m_pend, m_rl;
    int          m_st;

    j_pulse_ctl dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .pa       (pa),
        .pb       (pb),
        .pstop    (pstop),
        .pulse_in (pulse_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge and return what the DUT must show afterwards
    task automatic model_step(input logic rst, input logic we, input logic [1:0] wa,
                              input logic [15:0] wd, input logic [1:0] ra, input logic pin,
                              output exp_t e);
        int   period;
        int   nst;
        logic hit;
        logic stop_wr;
        logic reload_go;
        logic [1:0] st2;
        if (rst) begin
            m_en = 0; m_os = 0; m_ie = 0;
            m_a = 0; m_b = 0; m_pa = 0; m_pb = 0;
            m_tgt = 0; m_cnt = 0; m_pend = 0; m_rl = 0;
            m_st = S_IDLE;
            e.rd = 16'd0;
        end else begin
            st2 = m_st[1:0];
            case (ra)
                2'd0:    e.rd = {13'd0, m_ie, m_os, m_en};
                2'd1:    e.rd = {1'b0, m_b, m_a};
                2'd2:    e.rd = m_tgt;
                default: e.rd = {m_cnt[11:0], m_rl, st2, m_pend};
            endcase
            period    = (m_tgt == 16'd0) ? 1 : int'(m_tgt);
            hit       = (m_st == S_RUN) && pin && (int'(m_cnt) == period - 1);
            stop_wr   = we && (wa == 2'd0) && !wd[0] && (m_st != S_IDLE);
            reload_go = pin && m_rl;
            nst = m_st;
            if (m_st == S_IDLE) begin
                nst = m_en ? S_LOAD : S_IDLE;
            end else if (m_st == S_LOAD) begin
                m_pa = m_a;
                m_pb = m_b;
                m_rl = 0;
                nst = stop_wr ? S_IDLE : S_RUN;
            end else begin
                if (pin) m_cnt = hit ? 16'd0 : m_cnt + 16'd1;
                if (stop_wr || (hit && m_os)) nst = S_IDLE;
                else if (reload_go) nst = S_LOAD;
                if (hit && m_os) m_en = 0;
                if (we && wa == 2'd1) m_rl = 1;
            end
            if (we) begin
                case (wa)
                    2'd0: begin m_en = wd[0]; m_os = wd[1]; m_ie = wd[2]; end
                    2'd1: begin m_a = wd[7:0]; m_b = wd[14:8]; end
                    2'd2: m_tgt = wd;
                    default: if (wd[0]) m_pend = 0;
                endcase
            end
            if (hit) m_pend = 1;
            if (nst == S_IDLE) begin
                m_cnt = 0;
                m_rl = 0;
            end
            m_st = nst;
        end
        e.pa    = m_pa;
        e.pb    = m_pb;
        e.pstop = (m_st != S_RUN);
        e.irq   = m_pend & m_ie;
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge response
    task automatic cycle(input logic rst, input logic we, input logic [1:0] wa,
                         input logic [15:0] wd, input logic [1:0] ra, input logic pin);
        exp_t e;
        @(posedge clk);
        #2;
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra; pulse_in = pin;
        model_step(rst, we, wa, wd, ra, pin, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] ra);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 16'd0, ra, 1'b0);
    endtask

    task automatic wr(input logic [1:0] wa, input logic [15:0] wd);
        cycle(1'b0, 1'b1, wa, wd, 2'd3, 1'b0);
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 16'd0, 2'd3, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 2'd0, 16'hFFFF, 2'd3, 1'b1);
        cycle(1'b1, 1'b0, 2'd0, 16'd0, 2'd3, 1'b0);
    endtask

    // Monitor: compare every queued response one step after its edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data", int'(rd_data), int'(e.rd));
                check("pa", int'(pa), int'(e.pa));
                check("pb", int'(pb), int'(e.pb));
                check("pstop", int'(pstop), int'(e.pstop));
                check("irq", int'(irq), int'(e.irq));
            end
        end
    end

    initial begin
        logic        r_rst, r_we, r_pin;
        logic [1:0]  r_wa, r_ra;
        logic [15:0] r_wd;
        reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'd0; rd_addr = 2'd0; pulse_in = 1'b0;
        m_st = S_IDLE;

        do_reset();
        idle(1, 2'd3);
        check("reset_rd", int'(rd_data), 0);
        check("reset_pstop", int'(pstop), 1);
        check("reset_irq", int'(irq), 0);

        // Basic periodic run with interrupt
        wr(2'd1, 16'h0305);
        wr(2'd2, 16'd3);
        wr(2'd0, 16'h0005);
        idle(3, 2'd3);
        pulse(3);
        idle(1, 2'd3);
        check("s1_pa", int'(pa), 8'h05);
        check("s1_pb", int'(pb), 7'h03);
        check("s1_irq", int'(irq), 1);
        check("s1_pstop", int'(pstop), 0);
        idle(1, 2'd0);

        // Oneshot completion disables and halts
        do_reset();
        wr(2'd2, 16'd2);
        wr(2'd0, 16'h0007);
        idle(3, 2'd3);
        pulse(2);
        idle(1, 2'd0);
        check("s2_irq", int'(irq), 1);
        check("s2_pstop", int'(pstop), 1);
        pulse(3);
        idle(2, 2'd3);

        // Divider change while running waits for the next pulse
        do_reset();
        wr(2'd1, 16'h0305);
        wr(2'd2, 16'd100);
        wr(2'd0, 16'h0001);
        idle(3, 2'd3);
        pulse(1);
        wr(2'd1, 16'h0A10);
        idle(1, 2'd3);
        check("s3_pa_hold", int'(pa), 8'h05);
        pulse(1);
        idle(1, 2'd3);
        check("s3_load_pstop", int'(pstop), 1);
        idle(1, 2'd3);
        check("s3_pa_new", int'(pa), 8'h10);
        check("s3_pb_new", int'(pb), 7'h0A);
        idle(1, 2'd3);

        // Terminal pulse coincident with W1C clear keeps pending
        do_reset();
        wr(2'd2, 16'd1);
        wr(2'd0, 16'h0005);
        idle(3, 2'd3);
        cycle(1'b0, 1'b1, 2'd3, 16'h0001, 2'd3, 1'b1);
        idle(1, 2'd3);
        check("s4_irq", int'(irq), 1);
        wr(2'd3, 16'hFFFF);
        idle(2, 2'd3);

        // Reset mid-run with a non-zero count
        wr(2'd2, 16'd50);
        idle(2, 2'd3);
        pulse(5);
        idle(1, 2'd3);
        cycle(1'b1, 1'b1, 2'd1, 16'h1234, 2'd3, 1'b1);
        idle(1, 2'd3);
        check("s5_pstop", int'(pstop), 1);
        check("s5_pa", int'(pa), 0);
        idle(1, 2'd3);
        check("s5_status", int'(rd_data), 0);

        // Target zero: every pulse is an event
        wr(2'd0, 16'h0005);
        idle(3, 2'd3);
        pulse(1);
        wr(2'd3, 16'h0001);
        pulse(1);
        idle(2, 2'd3);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_we  = ($urandom_range(0, 9) < 3);
            r_wa  = 2'($urandom_range(0, 3));
            r_ra  = 2'($urandom_range(0, 3));
            r_pin = ($urandom_range(0, 9) < 4);
            r_wd  = 16'($urandom);
            if (r_wa == 2'd0 && $urandom_range(0, 9) < 8) r_wd[0] = 1'b1;
            if (r_wa == 2'd2 && $urandom_range(0, 9) < 9) r_wd = 16'($urandom_range(0, 6));
            if (r_wa == 2'd3 && $urandom_range(0, 1) == 0) r_wd[0] = 1'b0;
            cycle(r_rst, r_we, r_wa, r_wd, r_ra, r_pin);
        end
        idle(2, 2'd3);

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
